// File: rtl/avalon_cfg_master_pkg.sv
// Shared definitions for the packet-generator control-slave initiator:
// register map, FSM state encoding and the captured-command record.
package avalon_cfg_master_pkg;

  localparam logic [2:0] REG_NUMPKTS   = 3'd0;
  localparam logic [2:0] REG_START     = 3'd1;
  localparam logic [2:0] REG_STOP      = 3'd2;
  localparam logic [2:0] REG_PKTLENGTH = 3'd3;
  localparam logic [2:0] REG_PAYLOAD   = 3'd4;
  localparam logic [2:0] REG_VERSION   = 3'd5;
  localparam logic [2:0] REG_SCRATCH   = 3'd6;
  localparam logic [2:0] REG_RES       = 3'd7;

  localparam logic [7:0] VERSION_VALUE = 8'h12;

  localparam int STALL_W = 8;
  localparam int LAT_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RSP    = 2'd3
  } avm_state_t;

  typedef struct packed {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
  } avm_cmd_t;

  // Stall counter never wraps, so a stuck slave cannot alias back below TIMEOUT.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == {STALL_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/avalon_cfg_master.sv
// Command-port to Avalon-MM initiator: one bus transfer per command, one
// response pulse per transfer, with waitrequest stall timeout.
module avalon_cfg_master
  import avalon_cfg_master_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata
);

  localparam logic [LAT_W-1:0]   LAT_LOAD    = LAT_W'(READ_LATENCY - 1);
  localparam logic [STALL_W-1:0] TIMEOUT_CNT = STALL_W'(TIMEOUT);
  localparam bit                 TIMEOUT_EN  = (TIMEOUT != 0);

  avm_state_t          state_q, state_d;
  logic                cmd_write_q, cmd_write_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [STALL_W-1:0]  stall_inc;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                timeout_q, timeout_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
  logic                avm_read_q, avm_read_d;
  logic                avm_write_q, avm_write_d;
  logic [DATA_W-1:0]   avm_writedata_q, avm_writedata_d;

  assign stall_inc = sat_inc(stall_cnt_q);

  always_comb begin
    state_d         = state_q;
    cmd_write_d     = cmd_write_q;
    stall_cnt_d     = stall_cnt_q;
    lat_cnt_d       = lat_cnt_q;
    timeout_d       = timeout_q;
    cmd_ready_d     = cmd_ready_q;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_timeout_d   = 1'b0;
    avm_address_d   = avm_address_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    avm_writedata_d = avm_writedata_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_write_d     = cmd_write;
          avm_address_d   = cmd_addr;
          avm_writedata_d = cmd_write ? cmd_wdata : '0;
          avm_read_d      = ~cmd_write;
          avm_write_d     = cmd_write;
          stall_cnt_d     = '0;
          timeout_d       = 1'b0;
          rsp_rdata_d     = '0;
          cmd_ready_d     = 1'b0;
          state_d         = REQ;
        end
      end

      REQ: begin
        if (!avm_waitrequest) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (cmd_write_q) begin
            state_d = RSP;
          end else begin
            lat_cnt_d = LAT_LOAD;
            state_d   = RDWAIT;
          end
        end else begin
          stall_cnt_d = stall_inc;
          if (TIMEOUT_EN && (stall_inc == TIMEOUT_CNT)) begin
            avm_read_d  = 1'b0;
            avm_write_d = 1'b0;
            timeout_d   = 1'b1;
            state_d     = RSP;
          end
        end
      end

      RDWAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end else begin
          rsp_rdata_d = avm_readdata;
          state_d     = RSP;
        end
      end

      RSP: begin
        // Response pulse and readiness come up on the same edge, so a new
        // command can be accepted while the response is on the port.
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = timeout_q;
        cmd_ready_d   = 1'b1;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cmd_write_q     <= 1'b0;
      stall_cnt_q     <= '0;
      lat_cnt_q       <= '0;
      timeout_q       <= 1'b0;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_timeout_q   <= 1'b0;
      avm_address_q   <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      cmd_write_q     <= cmd_write_d;
      stall_cnt_q     <= stall_cnt_d;
      lat_cnt_q       <= lat_cnt_d;
      timeout_q       <= timeout_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_timeout_q   <= rsp_timeout_d;
      avm_address_q   <= avm_address_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign avm_address   = avm_address_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;

endmodule

// File: tb/tb_avalon_cfg_master.sv
// Directed bench for avalon_cfg_master against an 8-register slave model
// (read latency 1), with response and bus-transfer scoreboards.
module tb_avalon_cfg_master;
  import avalon_cfg_master_pkg::*;

  localparam int PERIOD = 10;

  typedef struct {
    logic [7:0] rdata;
    logic       to;
    int         lat;
    int         acc;
  } rsp_exp_t;

  typedef struct {
    avm_cmd_t cmd;
    int       cycles;
  } bus_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic [2:0] avm_address;
  logic       avm_read, avm_write;
  logic [7:0] avm_writedata;
  logic       avm_waitrequest;
  logic [7:0] avm_readdata = 8'h00;

  logic [7:0] regs [8] = '{default: 8'h00};
  bit         stuck = 1'b0;
  int         stall_req = 0;
  int         stall_seen = 0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  rsp_exp_t rsp_q[$];
  bus_exp_t bus_q[$];

  always #(PERIOD/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_cfg_master #(
    .ADDR_W(3), .DATA_W(8), .READ_LATENCY(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata)
  );

  // Slave model: VERSION and RES ignore writes; readdata valid one cycle after acceptance.
  assign avm_waitrequest = stuck || ((avm_read || avm_write) && (stall_seen < stall_req));

  always @(posedge clk) begin
    if (!(avm_read || avm_write)) stall_seen <= 0;
    else if (avm_waitrequest) stall_seen <= stall_seen + 1;
    if (avm_write && !avm_waitrequest && avm_address != REG_VERSION && avm_address != REG_RES)
      regs[avm_address] <= avm_writedata;
    if (avm_read && !avm_waitrequest)
      avm_readdata <= (avm_address == REG_VERSION) ? VERSION_VALUE :
                      (avm_address == REG_RES) ? 8'h00 : regs[avm_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic w, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] erd, input logic eto, input int elat,
                      input int ereq, input bit push, output int acc);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    acc = cyc;
    if (push) begin
      rsp_q.push_back('{rdata: erd, to: eto, lat: elat, acc: acc});
      bus_q.push_back('{cmd: '{write: w, addr: a, wdata: d}, cycles: ereq});
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0 || bus_q.size() != 0)
      chk("drain_timeout", 32'(rsp_q.size() + bus_q.size()), 32'd0);
  endtask

  // Response monitor
  initial begin : rsp_mon
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = rsp_q.pop_front();
          $display("rsp: rdata=%02h timeout=%0d latency=%0d", rsp_rdata, rsp_timeout, cyc - e.acc - 1);
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          chk("rsp_latency", 32'(cyc - e.acc - 1), 32'(e.lat));
        end
      end
    end
  end

  // Bus-transfer monitor
  initial begin : bus_mon
    avm_cmd_t cap;
    bus_exp_t b;
    int       cnt;
    bit       active;
    active = 1'b0;
    cnt = 0;
    cap = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else if (avm_read || avm_write) begin
        if (!active) begin
          active = 1'b1;
          cnt = 1;
          cap = '{write: avm_write, addr: avm_address, wdata: avm_writedata};
          chk("bus_one_hot", 32'(avm_read && avm_write), 32'd0);
        end else begin
          cnt++;
          chk("bus_addr_stable", 32'(avm_address), 32'(cap.addr));
          chk("bus_kind_stable", 32'(avm_write), 32'(cap.write));
        end
      end else if (active) begin
        active = 1'b0;
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_xfer", 32'(cnt), 32'd0);
        end else begin
          b = bus_q.pop_front();
          $display("bus: %s addr=%0d wdata=%02h cycles=%0d", cap.write ? "write" : "read",
                   cap.addr, cap.wdata, cnt);
          chk("bus_kind", 32'(cap.write), 32'(b.cmd.write));
          chk("bus_addr", 32'(cap.addr), 32'(b.cmd.addr));
          if (b.cmd.write) chk("bus_wdata", 32'(cap.wdata), 32'(b.cmd.wdata));
          chk("bus_req_cycles", 32'(cnt), 32'(b.cycles));
        end
      end
    end
  end

  initial begin : watchdog
    #(PERIOD * 5000);
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc, acc2;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_avm_address", 32'(avm_address), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Basic write, VERSION read, scratch write
    send(1'b1, REG_NUMPKTS, 8'h05, 8'h00, 1'b0, 2, 1, 1'b1, acc);
    send(1'b0, REG_VERSION, 8'h00, 8'h12, 1'b0, 3, 1, 1'b1, acc);
    send(1'b1, REG_SCRATCH, 8'hA5, 8'h00, 1'b0, 2, 1, 1'b1, acc);
    drain();

    // Three waitrequest cycles on a read
    stall_req = 3;
    send(1'b0, REG_SCRATCH, 8'h00, 8'hA5, 1'b0, 6, 4, 1'b1, acc);
    drain();
    stall_req = 0;

    // Stuck slave: abort after 4 stall cycles
    stuck = 1'b1;
    send(1'b0, REG_STOP, 8'h00, 8'h00, 1'b1, 5, 4, 1'b1, acc);
    drain();
    stuck = 1'b0;
    chk("timeout_cmd_ready", 32'(cmd_ready), 32'd1);

    // Read-only registers still receive the write on the bus
    send(1'b1, REG_VERSION, 8'h77, 8'h00, 1'b0, 2, 1, 1'b1, acc);
    send(1'b0, REG_VERSION, 8'h00, 8'h12, 1'b0, 3, 1, 1'b1, acc);
    send(1'b0, REG_NUMPKTS, 8'h00, 8'h05, 1'b0, 3, 1, 1'b1, acc);
    send(1'b1, REG_RES, 8'h33, 8'h00, 1'b0, 2, 1, 1'b1, acc);
    send(1'b0, REG_RES, 8'h00, 8'h00, 1'b0, 3, 1, 1'b1, acc);

    // Back-to-back writes: minimum period of 3 cycles
    send(1'b1, REG_START, 8'h10, 8'h00, 1'b0, 2, 1, 1'b1, acc);
    send(1'b1, REG_PKTLENGTH, 8'h20, 8'h00, 1'b0, 2, 1, 1'b1, acc2);
    chk("b2b_period", 32'(acc2 - acc), 32'd3);
    send(1'b0, REG_PKTLENGTH, 8'h00, 8'h20, 1'b0, 3, 1, 1'b1, acc);
    drain();

    // Reset while the request is on the bus
    stuck = 1'b1;
    send(1'b0, REG_PAYLOAD, 8'h00, 8'h00, 1'b0, 0, 0, 1'b0, acc);
    chk("midreq_read_high", 32'(avm_read), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_drop_read", 32'(avm_read), 32'd0);
    chk("async_drop_write", 32'(avm_write), 32'd0);
    chk("async_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    stuck = 1'b0;
    send(1'b0, REG_SCRATCH, 8'h00, 8'hA5, 1'b0, 3, 1, 1'b1, acc);
    send(1'b1, REG_PAYLOAD, 8'h3C, 8'h00, 1'b0, 2, 1, 1'b1, acc);
    send(1'b0, REG_PAYLOAD, 8'h00, 8'h3C, 1'b0, 3, 1, 1'b1, acc);
    drain();
    repeat (3) @(negedge clk);
    chk("final_rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
